// File: rtl/lcd_bus_ctrl_if.sv
// Request and LCD pin bundle for lcd_bus_ctrl.
// master: the requester (CPU/MMIO side); slave: the controller.
interface lcd_bus_ctrl_if #(
   parameter int unsigned DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_rs;
   logic [7:0]        req_data;
   logic [DATA_W-1:0] lcd_data;
   logic [1:0]        lcd_ctrl;
   logic              lcd_enable;
   logic              busy;

   modport master (
      output req_valid, req_rs, req_data,
      input  req_ready, lcd_data, lcd_ctrl, lcd_enable, busy
   );

   modport slave (
      input  req_valid, req_rs, req_data,
      output req_ready, lcd_data, lcd_ctrl, lcd_enable, busy
   );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// HD44780-style character-LCD write controller.
// Accepts byte writes over valid/ready and produces RS/RW/E timing with
// configurable setup, pulse and hold lengths; 8-bit or 4-bit (high nibble
// first) bus. Optional macro LCD_INIT_SEQ_EN adds an autonomous four-command
// init sequence after reset release.
module lcd_bus_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned PULSE_CYC = 4,
   parameter int unsigned HOLD_CYC  = 20,
   parameter int unsigned CNT_W     = 8
) (
   input logic           clk,
   input logic           rst_n,
   lcd_bus_ctrl_if.slave bus
);

   // Zero-length phases are stretched to one cycle.
   localparam int unsigned SetupN = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
   localparam int unsigned PulseN = (PULSE_CYC == 0) ? 1 : PULSE_CYC;
   localparam int unsigned HoldN  = (HOLD_CYC == 0) ? 1 : HOLD_CYC;

   // The counter is loaded with N-1 and the phase ends on the edge that sees 0.
   localparam logic [CNT_W-1:0] SetupLd = CNT_W'(SetupN - 1);
   localparam logic [CNT_W-1:0] PulseLd = CNT_W'(PulseN - 1);
   localparam logic [CNT_W-1:0] HoldLd  = CNT_W'(HoldN - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        byte_q, byte_d;
   logic              rs_q, rs_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              en_q, en_d;
   logic              lo_q, lo_d;     // low nibble currently on the bus
   logic              init_done;
   logic [7:0]        init_cmd;

`ifdef LCD_INIT_SEQ_EN
   logic [2:0] init_idx_q, init_idx_d;

   assign init_done = (init_idx_q == 3'd4);

   // Init command table; function set depends on the bus width.
   always_comb begin
      init_cmd = 8'h01;
      case (init_idx_q)
         3'd0:    init_cmd = (DATA_W == 8) ? 8'h38 : 8'h28;
         3'd1:    init_cmd = 8'h0C;
         3'd2:    init_cmd = 8'h06;
         default: init_cmd = 8'h01;
      endcase
   end

   // Init sequence position; restarts from the first command on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) init_idx_q <= 3'd0;
      else        init_idx_q <= init_idx_d;
   end
`else
   assign init_done = 1'b1;
   assign init_cmd  = 8'h00;
`endif

   // Next-state: launch from idle, then walk setup -> pulse -> hold per nibble.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      rs_d    = rs_q;
      data_d  = data_q;
      en_d    = en_q;
      lo_d    = lo_q;
`ifdef LCD_INIT_SEQ_EN
      init_idx_d = init_idx_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!init_done || bus.req_valid) begin
               byte_d  = init_done ? bus.req_data : init_cmd;
               rs_d    = init_done ? bus.req_rs : 1'b0;
               data_d  = byte_d[7 -: DATA_W];
               lo_d    = 1'b0;
               cnt_d   = SetupLd;
               state_d = StSetup;
`ifdef LCD_INIT_SEQ_EN
               if (!init_done) init_idx_d = init_idx_q + 3'd1;
`endif
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               en_d    = 1'b1;
               cnt_d   = PulseLd;
               state_d = StPulse;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StPulse: begin
            if (cnt_q == '0) begin
               en_d    = 1'b0;
               cnt_d   = HoldLd;
               state_d = StHold;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               if (DATA_W == 4 && !lo_q) begin
                  lo_d    = 1'b1;
                  data_d  = byte_q[DATA_W-1:0];
                  cnt_d   = SetupLd;
                  state_d = StSetup;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered pin drivers; reset drops E asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         byte_q  <= 8'h00;
         rs_q    <= 1'b0;
         data_q  <= '0;
         en_q    <= 1'b0;
         lo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         en_q    <= en_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.req_ready  = (state_q == StIdle) && init_done;
   assign bus.busy       = (state_q != StIdle) || !init_done;
   assign bus.lcd_data   = data_q;
   assign bus.lcd_ctrl   = {1'b0, rs_q};
   assign bus.lcd_enable = en_q;

endmodule

// File: doc/lcd_bus_ctrl.md
Name: lcd_bus_ctrl

Overview:
- Parametrised HD44780-style character-LCD write controller; successor to the fixed 8-bit LCD pins on the top-level (lcd_data, lcd_ctrl, lcd_enable).
- Accepts byte writes from the CPU/MMIO side over a valid/ready handshake.
- Generates the RS/RW/E timing with configurable setup, pulse and hold cycle counts.
- Supports 8-bit or 4-bit (two-nibble) bus mode.

Parameters:
- DATA_W, 8, LCD data bus width; legal values 8 or 4 (4 = nibble mode, high nibble first).
- SETUP_CYC, 2, cycles with data/ctrl stable and E low before E rises.
- PULSE_CYC, 4, cycles E is held high.
- HOLD_CYC, 20, cycles after E falls before the next transfer/nibble may start (covers LCD execution time).
- CNT_W, 8, width of the internal timing counter; every *_CYC value must be < 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  write request present
- req_ready  out  1  controller can accept a request
- req_rs  in  1  register select (0 = command, 1 = data)
- req_data  in  8  byte to write
- lcd_data  out  DATA_W  LCD data bus
- lcd_ctrl  out  2  [0] = RS, [1] = RW (RW is always 0; write-only)
- lcd_enable  out  1  LCD E strobe
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; lcd_data = 0, lcd_ctrl = 0, lcd_enable = 0 immediately; busy = 0, req_ready = 1.
  - Assertion mid-transfer abandons the transfer; E drops in the same instant; no resume after release.
- States: IDLE, SETUP, PULSE, HOLD. Single down-counter reused for all three timed states; *_CYC values of 0 are treated as 1.
- Acceptance: req_valid && req_ready sampled at edge k.
  - Latch req_rs and req_data at edge k; drive lcd_ctrl = {1'b0, rs} at edge k.
  - Drive lcd_data = byte (DATA_W = 8) or byte[7:4] (DATA_W = 4) at edge k; go to SETUP.
  - req_ready is combinational (state == IDLE), so it is low from edge k.
- SETUP: E = 0 for SETUP_CYC cycles, then PULSE; E rises at edge k+SETUP_CYC.
- PULSE: E = 1 for PULSE_CYC cycles; E falls at edge k+SETUP_CYC+PULSE_CYC.
- HOLD: E = 0 for HOLD_CYC cycles. lcd_data and lcd_ctrl stay stable throughout SETUP, PULSE and HOLD.
- HOLD end, DATA_W = 8, or DATA_W = 4 with low nibble done: go to IDLE; ready again at edge k+S+P+H.
- HOLD end, DATA_W = 4, high nibble just sent: drive lcd_data = byte[3:0] and return to SETUP. Total transfer = 2*(S+P+H) cycles.
- lcd_data/lcd_ctrl hold their last value in IDLE; no return to 0.
- Requests while busy are not accepted (ready = 0); requester must hold valid/data until accepted.
- Back-to-back: valid held high gets the next acceptance in the same cycle ready returns. No dead cycle beyond HOLD.
- All outputs are registered except req_ready and busy, which decode state only.

Optional Feature:
- Macro LCD_INIT_SEQ_EN.
- Defined:
  - After reset release, the controller autonomously issues four command writes (rs = 0), with normal timing and nibble splitting:
    - function set: 0x38 if DATA_W = 8, 0x28 if DATA_W = 4
    - 0x0C display on
    - 0x06 entry mode
    - 0x01 clear
  - req_ready = 0 and busy = 1 throughout the sequence; user requests are accepted only after the last HOLD.
  - Reset mid-sequence restarts the sequence from the first command.
- Undefined: controller is idle and ready immediately after reset; no automatic writes.

Test Plan:
- Reset then idle (DATA_W = 8, macro off) -> lcd_enable = 0, lcd_data = 0x00, lcd_ctrl = 2'b00, req_ready = 1 on the first cycle after rst_n rises.
- One request rs = 1, data 0x41, defaults -> lcd_data = 0x41, lcd_ctrl = 2'b01 from edge k; E high exactly at edges k+2..k+5, low at k+6; req_ready = 1 again at k+26.
- DATA_W = 4, rs = 0, data 0x28 -> two E pulses, lcd_data = 0x2 on the first, 0x8 on the second; second E rises at k+28; ready at k+52.
- Back-to-back: valid held with 0x48 then 0x49 -> second acceptance on the exact cycle ready returns (k+26); exactly 2 E pulses total; no write while busy.
- rst_n low during PULSE of a write -> lcd_enable = 0 immediately (asynchronous); outputs = 0; after release, ready = 1 and no further pulses.
- LCD_INIT_SEQ_EN, DATA_W = 8 -> E pulses carry 0x38, 0x0C, 0x06, 0x01 with rs = 0; a user request held from reset is accepted only at cycle 4*26 = 104.
